// File: rtl/mem_pipe_pkg.sv
// Shared types and helpers for the pipelined memory model and its response FIFO.
package mem_pipe_pkg;

    localparam int MEM_WIDTH = 64;
    localparam int MEM_BYTES = MEM_WIDTH / 8;

    typedef struct packed {
        logic [MEM_WIDTH-1:0] rd_data;
        logic                 we;
        logic                 err;
    } mem_rsp_t;

    // Expand one enable bit per byte into a full-width bit mask.
    function automatic logic [MEM_WIDTH-1:0] expand_be(input logic [MEM_BYTES-1:0] be);
        logic [MEM_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response FIFO; head is valid whenever empty is low.
module mem_rsp_fifo
    import mem_pipe_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = mem_rsp_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        entries [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = entries[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_pipe.sv
// Word-addressed memory with valid/ready channels, fixed read latency, byte-enable
// writes and an out-of-range error flag; responses return strictly in order.
module mem_pipe
    import mem_pipe_pkg::*;
#(
    parameter int WIDTH       = MEM_WIDTH,
    parameter int DEPTH       = 8192,
    parameter int DEPTH__LOG2 = 13,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DEPTH__LOG2-1:0] req_addr,
    input  logic                   req_we,
    input  logic [WIDTH/8-1:0]     req_be,
    input  logic [WIDTH-1:0]       req_wr_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_rd_data,
    output logic                   rsp_we,
    output logic                   rsp_err
);

    localparam int NB = WIDTH / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] rd_data;
        logic             we;
        logic             err;
    } rsp_t;

    if (LATENCY < 1) begin : g_chk_latency
        $error("mem_pipe: LATENCY must be at least 1");
    end
    if (RSP_DEPTH < LATENCY + 1) begin : g_chk_rsp_depth
        $error("mem_pipe: RSP_DEPTH must be at least LATENCY+1");
    end
    if (WIDTH % 8 != 0) begin : g_chk_width
        $error("mem_pipe: WIDTH must be a multiple of 8");
    end
    if (AW > DEPTH__LOG2) begin : g_chk_addr
        $error("mem_pipe: DEPTH__LOG2 too small for DEPTH");
    end

    logic [WIDTH-1:0]   memory [DEPTH];
    logic [WIDTH-1:0]   stg_data_reg [LATENCY];
    logic [LATENCY-1:0] stg_valid_reg;
    logic [LATENCY-1:0] stg_we_reg;
    logic [LATENCY-1:0] stg_err_reg;
    logic [OW-1:0]      outstanding_reg;
    logic [OW-1:0]      outstanding_next;
    logic               req_ready_reg;
    logic               accept;
    logic               addr_err;
    logic               rsp_hs;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW-1:0]      mem_idx;
    rsp_t               push_entry;
    rsp_t               head_entry;

    assign req_ready = req_ready_reg;
    assign accept    = req_valid && req_ready_reg;
    assign rsp_hs    = rsp_valid && rsp_ready;
    // One extra bit so DEPTH == 2**DEPTH__LOG2 still compares correctly.
    assign addr_err  = ({1'b0, req_addr} >= (DEPTH__LOG2 + 1)'(DEPTH));
    assign mem_idx   = req_addr[AW-1:0];

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !rsp_hs) begin
            outstanding_next = outstanding_reg + 1'b1;
        end else if (!accept && rsp_hs) begin
            outstanding_next = outstanding_reg - 1'b1;
        end
    end

    // Array and data pipeline carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept && !addr_err) begin
            if (req_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_be[b]) begin
                        memory[mem_idx][b*8 +: 8] <= req_wr_data[b*8 +: 8];
                    end
                end
            end
            stg_data_reg[0] <= memory[mem_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            stg_data_reg[i] <= stg_data_reg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_valid_reg   <= '0;
            stg_we_reg      <= '0;
            stg_err_reg     <= '0;
            outstanding_reg <= '0;
            req_ready_reg   <= 1'b1;
        end else begin
            stg_valid_reg[0] <= accept;
            stg_we_reg[0]    <= req_we;
            stg_err_reg[0]   <= addr_err;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid_reg[i] <= stg_valid_reg[i-1];
                stg_we_reg[i]    <= stg_we_reg[i-1];
                stg_err_reg[i]   <= stg_err_reg[i-1];
            end
            outstanding_reg <= outstanding_next;
            req_ready_reg   <= (outstanding_next < OW'(RSP_DEPTH));
        end
    end

    // Writes and errors return zero data; the raw array word is discarded.
    always_comb begin
        push_entry.we      = stg_we_reg[LATENCY-1];
        push_entry.err     = stg_err_reg[LATENCY-1];
        push_entry.rd_data = (stg_we_reg[LATENCY-1] || stg_err_reg[LATENCY-1])
                             ? '0 : stg_data_reg[LATENCY-1];
    end

    mem_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (stg_valid_reg[LATENCY-1]),
        .push_data (push_entry),
        .pop       (rsp_hs),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rsp_valid   = !fifo_empty;
    assign rsp_rd_data = rsp_valid ? head_entry.rd_data : '0;
    assign rsp_we      = rsp_valid && head_entry.we;
    assign rsp_err     = rsp_valid && head_entry.err;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        outstanding_reg <= OW'(RSP_DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(rsp_hs && !accept && outstanding_reg == '0));
    a_fifo_room: assert property (@(posedge clk) disable iff (!rst)
        !(stg_valid_reg[LATENCY-1] && fifo_full));

endmodule

// File: tb/tb_mem_pipe.sv
// Directed scoreboard bench for mem_pipe: stimulus pushes expected responses,
// a negedge monitor pops and compares each completed response handshake.
module tb_mem_pipe;
    import mem_pipe_pkg::*;

    localparam int DEPTH = 6000;
    localparam int LOG2  = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [12:0] req_addr;
    logic        req_we;
    logic [7:0]  req_be;
    logic [63:0] req_wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rd_data;
    logic        rsp_we;
    logic        rsp_err;

    typedef struct packed {
        logic [63:0] d;
        logic        we;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] shadow[int];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rsp    = 0;
    int          cyc      = 0;
    int          last_acc_cyc = 0;
    int          tp_mode = 0;
    int          tp_seen = 0;
    int          tp_bubbles = 0;

    mem_pipe #(
        .WIDTH       (64),
        .DEPTH       (DEPTH),
        .DEPTH__LOG2 (LOG2),
        .LATENCY     (2),
        .RSP_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_be      (req_be),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rd_data (rsp_rd_data),
        .rsp_we      (rsp_we),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int a);
        return {32'hC0DE0000 | 32'(a), 32'h00001000 + 32'(a)};
    endfunction

    // Present one request, wait for acceptance, queue its expected response.
    task automatic send(input logic [12:0] a, input logic we, input logic [7:0] be,
                        input logic [63:0] d, input logic [63:0] exp_d, input logic exp_err);
        int   waited;
        exp_t e;
        waited = 0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_be = be; req_wr_data = d;
        @(negedge clk);
        while (!req_ready) begin
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_accept_timeout: addr %h never accepted", a);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.d = exp_d; e.we = we; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        logic        err;
        logic [63:0] exp_d;
        err   = (a >= DEPTH);
        exp_d = (err || !shadow.exists(a)) ? 64'h0 : shadow[a];
        send(13'(a), 1'b0, 8'h00, 64'h0, exp_d, err);
    endtask

    task automatic wr(input int a, input logic [7:0] be, input logic [63:0] d);
        logic [63:0] m;
        logic [63:0] old;
        m = expand_be(be);
        if (a < DEPTH) begin
            old = shadow.exists(a) ? shadow[a] : 64'h0;
            shadow[a] = (old & ~m) | (d & m);
        end
        send(13'(a), 1'b1, be, d, 64'h0, a >= DEPTH);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'h0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: one line per completed response, plus hold-stability checks.
    initial begin
        exp_t        e;
        logic        hold_prev;
        logic [65:0] prev_rsp;
        hold_prev = 1'b0;
        prev_rsp  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk1("hold_valid", rsp_valid, 1'b1);
                    chk("hold_fields", 64'({rsp_rd_data, rsp_we, rsp_err} != prev_rsp), 64'h0);
                end
                if (tp_mode != 0) begin
                    if (rsp_valid) tp_seen++;
                    else if (tp_seen > 0 && tp_seen < 100) tp_bubbles++;
                end
                if (rsp_valid && rsp_ready) begin
                    n_rsp++;
                    $display("rsp %0d: rd_data=%h we=%0b err=%0b", n_rsp, rsp_rd_data, rsp_we, rsp_err);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rd_data=%h, expected no response", rsp_rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rd_data", rsp_rd_data, e.d);
                        chk1("rsp_we", rsp_we, e.we);
                        chk1("rsp_err", rsp_err, e.err);
                    end
                end
                hold_prev = rsp_valid && !rsp_ready;
                prev_rsp  = {rsp_rd_data, rsp_we, rsp_err};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int a;
        int first_acc;
        int stale;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_be = '0; req_wr_data = '0; rsp_ready = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rd_data", rsp_rd_data, 64'h0);
        chk1("reset_rsp_we", rsp_we, 1'b0);
        chk1("reset_rsp_err", rsp_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("reset_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // Preload through the request port.
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) wr(i, 8'hff, pat(i));
        wr(5, 8'hff, 64'h0123456789abcdef);
        wr(7, 8'hff, 64'h1111111111111111);
        wait_drain("drain_preload");

        // Read latency: response visible two edges after acceptance.
        send(13'd5, 1'b0, 8'h00, 64'h0, 64'h0123456789abcdef, 1'b0);
        chk1("lat_edge0", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk1("lat_edge1", rsp_valid, 1'b0);
        @(posedge clk); #1;
        chk1("lat_edge2", rsp_valid, 1'b1);
        wait_drain("drain_latency");

        // Partial byte-enable write then read-back.
        wr(7, 8'h0f, 64'hffffffffffffffff);
        send(13'd7, 1'b0, 8'h00, 64'h0, 64'h11111111ffffffff, 1'b0);
        wait_drain("drain_be");

        // Out-of-range read and write.
        send(13'h1fff, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
        send(13'd6000, 1'b1, 8'hff, 64'hdeadbeefdeadbeef, 64'h0, 1'b1);
        send(13'd5999, 1'b0, 8'h00, 64'h0, 64'h0, 1'b0);
        wait_drain("drain_err");

        // Backpressure: only RSP_DEPTH requests get in.
        rsp_ready = 1'b0;
        acc = 0;
        a = 20;
        for (int c = 0; c < 10; c++) begin
            exp_t e;
            req_valid = 1'b1; req_addr = 13'(a); req_we = 1'b0; req_be = 8'h00;
            @(negedge clk);
            if (req_ready) begin
                e.d = shadow[a]; e.we = 1'b0; e.err = 1'b0;
                exp_q.push_back(e);
                acc++;
                a++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'd4);
        chk1("bp_req_ready_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk1("bp_ready_before_hs", req_ready, 1'b0);
        chk1("bp_rsp1_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        chk1("bp_ready_after_hs", req_ready, 1'b1);
        @(negedge clk);
        chk1("bp_rsp2_valid", rsp_valid, 1'b1);
        @(negedge clk);
        chk1("bp_rsp3_valid", rsp_valid, 1'b1);
        @(negedge clk);
        chk1("bp_rsp4_valid", rsp_valid, 1'b1);
        @(negedge clk);
        chk1("bp_drained", rsp_valid, 1'b0);
        wait_drain("drain_bp");

        // Throughput: 100 back-to-back reads.
        tp_seen = 0; tp_bubbles = 0; tp_mode = 1;
        rd(0);
        first_acc = last_acc_cyc;
        for (int i = 1; i < 100; i++) rd(i);
        chk("tp_accept_cycles", 64'(last_acc_cyc - first_acc), 64'd99);
        wait_drain("drain_tp");
        tp_mode = 0;
        chk("tp_responses", 64'(tp_seen), 64'd100);
        chk("tp_bubbles", 64'(tp_bubbles), 64'd0);

        // Reset with three responses outstanding.
        rsp_ready = 1'b0;
        rd(1); rd(2); rd(3);
        repeat (3) @(posedge clk);
        #3;
        chk1("midrst_pre_valid", rsp_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk1("midrst_valid_drop", rsp_valid, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("midrst_stale", 64'(stale), 64'd0);
        chk1("midrst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(13'd7, 1'b0, 8'h00, 64'h0, 64'h11111111ffffffff, 1'b0);
        send(13'd5, 1'b0, 8'h00, 64'h0, 64'h0123456789abcdef, 1'b0);
        rd(42);
        wait_drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
